// File: rtl/imem_boot_loader_if.sv
// Byte-source handshake, imem write port and core control bundle for imem_boot_loader.
// The master side is the byte source or testbench. The slave side is the loader.
interface imem_boot_loader_if #(
  parameter int unsigned AW = 6
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          reload;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          core_reset;
  logic          done;
  logic          error;

  modport master (
    output rx_valid, rx_data, reload,
    input  rx_ready, we, waddr, wdata, core_reset, done, error
  );

  modport slave (
    input  rx_valid, rx_data, reload,
    output rx_ready, we, waddr, wdata, core_reset, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Byte-serial imem loader. It receives a length-prefixed, checksummed image, writes it to imem,
// and holds the core in reset until the image has been verified.
module imem_boot_loader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic               clk,
  input  logic               reset,
  imem_boot_loader_if.slave  bus
);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CHK, S_RUN, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    sum_q, sum_d;
  logic [15:0]   len_q, len_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [23:0]   asm_q, asm_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          core_reset_q, core_reset_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          rx_ready_c;
  logic          accept;
  logic [15:0]   len_n;
  logic [PW-1:0] wptr_inc;

  assign rx_ready_c = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CHK);
  assign accept     = bus.rx_valid & rx_ready_c;
  assign len_n      = {bus.rx_data, len_q[7:0]};
  assign wptr_inc   = wptr_q + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LEN0;
      sum_q        <= 8'd0;
      len_q        <= 16'd0;
      bidx_q       <= 2'd0;
      wptr_q       <= '0;
      asm_q        <= 24'd0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= 32'd0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      len_q        <= len_d;
      bidx_q       <= bidx_d;
      wptr_q       <= wptr_d;
      asm_q        <= asm_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Next state, image parsing and registered output updates
  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    len_d        = len_q;
    bidx_d       = bidx_q;
    wptr_d       = wptr_q;
    asm_d        = asm_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    core_reset_d = core_reset_q;
    done_d       = done_q;
    error_d      = error_q;

    unique case (state_q)
      S_LEN0: if (accept) begin
        len_d   = {8'd0, bus.rx_data};
        sum_d   = bus.rx_data;
        state_d = S_LEN1;
      end
      S_LEN1: if (accept) begin
        len_d  = len_n;
        sum_d  = sum_q + bus.rx_data;
        wptr_d = '0;
        bidx_d = 2'd0;
        if (len_n > 16'(DEPTH)) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else if (len_n == 16'd0) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (accept) begin
        sum_d  = sum_q + bus.rx_data;
        bidx_d = bidx_q + 2'd1;
        unique case (bidx_q)
          2'd0: asm_d[7:0]   = bus.rx_data;
          2'd1: asm_d[15:8]  = bus.rx_data;
          2'd2: asm_d[23:16] = bus.rx_data;
          default: begin
            we_d    = 1'b1;
            wdata_d = {bus.rx_data, asm_q};
            waddr_d = wptr_q[AW-1:0];
            wptr_d  = wptr_inc;
            if (16'(wptr_inc) == len_q) state_d = S_CHK;
          end
        endcase
      end
      S_CHK: if (accept) begin
        if (bus.rx_data == sum_q) begin
          state_d      = S_RUN;
          core_reset_d = 1'b0;
          done_d       = 1'b1;
        end else begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end
      S_RUN: if (bus.reload) begin
        state_d      = S_LEN0;
        core_reset_d = 1'b1;
        done_d       = 1'b0;
      end
      default: state_d = S_ERR;
    endcase
  end

  assign bus.rx_ready   = rx_ready_c;
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.core_reset = core_reset_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader. Stimulus queues the expected imem writes, and a
// negedge monitor pops one entry and compares it on every we pulse.
module tb_imem_boot_loader;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  wr_t  exp_q[$];

  imem_boot_loader_if #(.AW(AW)) bif ();

  imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && bif.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'(bif.waddr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", 32'(bif.waddr), 32'(e.addr));
        chk("wdata", bif.wdata, e.data);
      end
    end
  end

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input bit stall);
    int t;
    @(negedge clk);
    if (stall) begin
      int n;
      n = int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
        chk("rx_ready_stall", 32'(bif.rx_ready), 32'd1);
        @(negedge clk);
      end
    end
    bif.rx_valid = 1'b1;
    bif.rx_data  = b;
    t = 0;
    while (bif.rx_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bif.rx_ready !== 1'b1) chk("send_timeout", 32'(bif.rx_ready), 32'd1);
    @(posedge clk);
    #1;
    bif.rx_valid = 1'b0;
  endtask

  task automatic send_img(input logic [7:0] img[$], input bit stall);
    foreach (img[i]) send(img[i], stall);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rx_ready"},   32'(bif.rx_ready),   32'd1);
    chk({tag, "_we"},         32'(bif.we),         32'd0);
    chk({tag, "_waddr"},      32'(bif.waddr),      32'd0);
    chk({tag, "_wdata"},      bif.wdata,           32'd0);
    chk({tag, "_core_reset"}, 32'(bif.core_reset), 32'd1);
    chk({tag, "_done"},       32'(bif.done),       32'd0);
    chk({tag, "_error"},      32'(bif.error),      32'd0);
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_done"},       32'(bif.done),       32'd1);
    chk({tag, "_core_reset"}, 32'(bif.core_reset), 32'd0);
    chk({tag, "_error"},      32'(bif.error),      32'd0);
    chk({tag, "_rx_ready"},   32'(bif.rx_ready),   32'd0);
    chk({tag, "_pending"},    32'(exp_q.size()),   32'd0);
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_error"},      32'(bif.error),      32'd1);
    chk({tag, "_core_reset"}, 32'(bif.core_reset), 32'd1);
    chk({tag, "_done"},       32'(bif.done),       32'd0);
    chk({tag, "_rx_ready"},   32'(bif.rx_ready),   32'd0);
  endtask

  // Byte sum of image A is 0x355, so CHK is 0x55. Byte sum of image B is 0x115, so CHK is 0x15.
  logic [7:0] img_a[$]  = '{8'h02, 8'h00, 8'h07, 8'h00, 8'hA0, 8'hE3,
                            8'h64, 8'h00, 8'h80, 8'hE5, 8'h55};
  logic [7:0] img_a_part[$] = '{8'h02, 8'h00, 8'h07, 8'h00, 8'hA0, 8'hE3, 8'h64, 8'h00};
  logic [7:0] img_b[$]  = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h15};
  logic [7:0] img_z0[$] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] img_z1[$] = '{8'h00, 8'h00, 8'h01};
  logic [7:0] img_big[$] = '{8'h41, 8'h00};

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    bif.reload   = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;

    // Back-to-back load of two words
    expect_wr(6'd0, 32'hE3A0_0007);
    expect_wr(6'd1, 32'hE580_0064);
    send_img(img_a, 1'b0);
    chk_run("load_a");

    // The same image with random stalls between bytes
    do_reset();
    expect_wr(6'd0, 32'hE3A0_0007);
    expect_wr(6'd1, 32'hE580_0064);
    send_img(img_a, 1'b1);
    chk_run("load_a_stall");

    // Empty image with a good checksum, then with a bad one
    do_reset();
    send_img(img_z0, 1'b0);
    chk_run("n0_ok");
    do_reset();
    send_img(img_z1, 1'b0);
    chk_err("n0_bad");
    @(negedge clk);
    bif.reload = 1'b1;
    @(posedge clk);
    #1;
    bif.reload = 1'b0;
    chk_err("err_reload");

    // Length larger than DEPTH
    do_reset();
    send_img(img_big, 1'b0);
    chk_err("n65");

    // Asynchronous reset in the middle of word 1
    do_reset();
    expect_wr(6'd0, 32'hE3A0_0007);
    send_img(img_a_part, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("mid_reset");
    chk("mid_reset_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_wr(6'd0, 32'hE3A0_0007);
    expect_wr(6'd1, 32'hE580_0064);
    send_img(img_a, 1'b0);
    chk_run("reload_after_reset");

    // Reload from RUN while a stray byte is offered. The stray byte must be ignored.
    @(negedge clk);
    bif.reload   = 1'b1;
    bif.rx_valid = 1'b1;
    bif.rx_data  = 8'hFF;
    @(posedge clk);
    #1;
    bif.reload   = 1'b0;
    bif.rx_valid = 1'b0;
    chk("reload_core_reset", 32'(bif.core_reset), 32'd1);
    chk("reload_done",       32'(bif.done),       32'd0);
    chk("reload_rx_ready",   32'(bif.rx_ready),   32'd1);
    expect_wr(6'd0, 32'h1234_5678);
    send_img(img_b, 1'b0);
    chk_run("load_b");

    repeat (3) @(negedge clk);
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
